// File: rtl/alu_defs.sv
// rtl/alu_defs.sv - shared ALU select, opcode/funct constants and decoded-bundle type
package alu_defs;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        ALU_FORWARD = 3'b000,
        ALU_ADD     = 3'b001,
        ALU_AND     = 3'b010,
        ALU_OR      = 3'b011,
        ALU_MUL     = 3'b100,
        ALU_SHIFT   = 3'b101
    } alu_sel_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        alu_sel_e          alu_select;
        logic [4:0]        rd;
        logic              reg_write_en;
        logic              illegal;
    } decoded_t;

endpackage

// File: rtl/rv32_alu_decoder.sv
// rtl/rv32_alu_decoder.sv - combinational RV32 decode of the ALU subset into an ID/EX bundle
module rv32_alu_decoder
    import alu_defs::*;
(
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    output logic [4:0]        rs1_addr,
    output logic [4:0]        rs2_addr,
    output decoded_t          dec
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd;
    logic [DATA_W-1:0] imm_i;
    logic              legal;

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];
    assign funct7   = instr[31:25];
    assign imm_i    = {{(DATA_W-12){instr[31]}}, instr[31:20]};

    always_comb begin
        dec            = '0;
        legal          = 1'b0;
        dec.rd         = rd;
        dec.alu_select = ALU_FORWARD;
        case (opcode)
            OPC_OP_IMM: begin
                dec.data1 = rs1_data;
                case (funct3)
                    F3_ADD: begin legal = 1'b1; dec.alu_select = ALU_ADD; dec.data2 = imm_i; end
                    F3_AND: begin legal = 1'b1; dec.alu_select = ALU_AND; dec.data2 = imm_i; end
                    F3_OR:  begin legal = 1'b1; dec.alu_select = ALU_OR;  dec.data2 = imm_i; end
                    F3_SLL, F3_SRL: begin
                        if (funct7 == F7_BASE) begin
                            legal          = 1'b1;
                            dec.alu_select = ALU_SHIFT;
                            // bit 5 tells the shifter the direction; low bits are the shamt
                            dec.data2      = {{(DATA_W-6){1'b0}}, funct3 == F3_SRL, instr[24:20]};
                        end
                    end
                    default: ;
                endcase
            end
            OPC_OP: begin
                dec.data1 = rs1_data;
                dec.data2 = rs2_data;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD: begin legal = 1'b1; dec.alu_select = ALU_ADD; end
                        F3_AND: begin legal = 1'b1; dec.alu_select = ALU_AND; end
                        F3_OR:  begin legal = 1'b1; dec.alu_select = ALU_OR;  end
                        F3_SLL, F3_SRL: begin
                            legal          = 1'b1;
                            dec.alu_select = ALU_SHIFT;
                            dec.data2      = {{(DATA_W-6){1'b0}}, funct3 == F3_SRL, rs2_data[4:0]};
                        end
                        default: ;
                    endcase
                end else if (funct7 == F7_MULDIV && funct3 == F3_ADD) begin
                    legal          = 1'b1;
                    dec.alu_select = ALU_MUL;
                end
            end
            OPC_LUI: begin
                legal          = 1'b1;
                dec.alu_select = ALU_FORWARD;
                dec.data1      = '0;
                dec.data2      = {instr[31:12], 12'b0};
            end
            default: ;
        endcase

        // unsupported encodings still travel down the pipe, but as an inert bundle
        if (!legal) begin
            dec.data1      = '0;
            dec.data2      = '0;
            dec.alu_select = ALU_FORWARD;
        end
        dec.illegal      = !legal;
        dec.reg_write_en = legal && (rd != 5'd0);
    end

endmodule

// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - ID stage: decode, operand read and ID/EX register with valid/ready
module alu_decode_stage
    import alu_defs::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      INSTR_IN,
    input  logic [31:0]      PC_IN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [4:0]       RS1_ADDR,
    output logic [4:0]       RS2_ADDR,
    input  logic [XLEN-1:0]  RS1_DATA,
    input  logic [XLEN-1:0]  RS2_DATA,
    input  logic             FLUSH,
    input  logic             OUT_READY,
    output logic             OUT_VALID,
    output logic [XLEN-1:0]  DATA1,
    output logic [XLEN-1:0]  DATA2,
    output logic [2:0]       ALU_SELECT,
    output logic [4:0]       RD_ADDR,
    output logic             REG_WRITE_EN,
    output logic             ILLEGAL,
    output logic [31:0]      PC_OUT,
    output logic [CNT_W-1:0] STALL_COUNT
);

    decoded_t   dec_next;
    decoded_t   bundle;
    logic       out_valid_q;
    logic [31:0] pc_q;
    logic [CNT_W-1:0] stall_q;
    logic       transfer;

    rv32_alu_decoder u_decoder (
        .instr    (INSTR_IN),
        .rs1_data (RS1_DATA),
        .rs2_data (RS2_DATA),
        .rs1_addr (RS1_ADDR),
        .rs2_addr (RS2_ADDR),
        .dec      (dec_next)
    );

    assign IN_READY = !out_valid_q || OUT_READY;
    assign transfer = IN_VALID && IN_READY;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_valid_q <= 1'b0;
            bundle      <= '0;
            pc_q        <= '0;
            stall_q     <= '0;
        end else begin
            if (FLUSH) begin
                out_valid_q <= 1'b0;
            end else if (transfer) begin
                out_valid_q <= 1'b1;
                bundle      <= dec_next;
                pc_q        <= PC_IN;
            end else if (out_valid_q && OUT_READY) begin
                out_valid_q <= 1'b0;
            end

            if (out_valid_q && !OUT_READY && !FLUSH && stall_q != {CNT_W{1'b1}}) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign OUT_VALID    = out_valid_q;
    assign DATA1        = bundle.data1;
    assign DATA2        = bundle.data2;
    assign ALU_SELECT   = bundle.alu_select;
    assign RD_ADDR      = bundle.rd;
    assign REG_WRITE_EN = bundle.reg_write_en;
    assign ILLEGAL      = bundle.illegal;
    assign PC_OUT       = pc_q;
    assign STALL_COUNT  = stall_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb/tb_alu_decode_stage.sv - directed scoreboard bench for alu_decode_stage
module tb_alu_decode_stage;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [2:0]  sel;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] INSTR_IN, PC_IN, RS1_DATA, RS2_DATA;
    logic        IN_VALID, IN_READY, FLUSH, OUT_READY, OUT_VALID;
    logic [4:0]  RS1_ADDR, RS2_ADDR, RD_ADDR;
    logic [31:0] DATA1, DATA2, PC_OUT;
    logic [2:0]  ALU_SELECT;
    logic        REG_WRITE_EN, ILLEGAL;
    logic [15:0] STALL_COUNT;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    always #5 CLK = ~CLK;

    alu_decode_stage #(.XLEN(32), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .INSTR_IN(INSTR_IN), .PC_IN(PC_IN),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR),
        .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA), .FLUSH(FLUSH), .OUT_READY(OUT_READY),
        .OUT_VALID(OUT_VALID), .DATA1(DATA1), .DATA2(DATA2), .ALU_SELECT(ALU_SELECT),
        .RD_ADDR(RD_ADDR), .REG_WRITE_EN(REG_WRITE_EN), .ILLEGAL(ILLEGAL), .PC_OUT(PC_OUT),
        .STALL_COUNT(STALL_COUNT)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] d1, d2, input logic [2:0] sel,
                                input logic [4:0] rd, input logic we, ill, input logic [31:0] pc);
        exp_t e;
        e.d1 = d1; e.d2 = d2; e.sel = sel; e.rd = rd; e.we = we; e.ill = ill; e.pc = pc;
        return e;
    endfunction

    // drive one cycle; an accepted instruction is scored right after the edge
    task automatic step(input logic [31:0] instr, pc, r1, r2,
                        input logic v, ordy, fl, input exp_t e);
        logic acc;
        exp_t got;
        INSTR_IN = instr; PC_IN = pc; RS1_DATA = r1; RS2_DATA = r2;
        IN_VALID = v; OUT_READY = ordy; FLUSH = fl;
        #1;
        acc = v && IN_READY && !fl;
        if (acc) sb.push_back(e);
        @(posedge CLK);
        #1;
        if (acc) begin
            got = sb.pop_front();
            chk("out_valid", {31'b0, OUT_VALID}, 32'd1);
            chk("data1", DATA1, got.d1);
            chk("data2", DATA2, got.d2);
            chk("alu_select", {29'b0, ALU_SELECT}, {29'b0, got.sel});
            chk("rd_addr", {27'b0, RD_ADDR}, {27'b0, got.rd});
            chk("reg_write_en", {31'b0, REG_WRITE_EN}, {31'b0, got.we});
            chk("illegal", {31'b0, ILLEGAL}, {31'b0, got.ill});
            chk("pc_out", PC_OUT, got.pc);
        end
    endtask

    exp_t none;

    initial begin
        none = mk(0, 0, 0, 0, 0, 0, 0);
        RESET = 1'b1; INSTR_IN = 0; PC_IN = 0; RS1_DATA = 0; RS2_DATA = 0;
        IN_VALID = 0; OUT_READY = 0; FLUSH = 0;
        #12;
        chk("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
        chk("rst_alu_select", {29'b0, ALU_SELECT}, 32'd0);
        chk("rst_data2", DATA2, 32'd0);
        chk("rst_pc_out", PC_OUT, 32'd0);
        chk("rst_stall_count", {16'b0, STALL_COUNT}, 32'd0);
        chk("rst_in_ready", {31'b0, IN_READY}, 32'd1);
        RESET = 1'b0;

        INSTR_IN = 32'hFFF0F113; #1;
        chk("rs1_addr_comb", {27'b0, RS1_ADDR}, 32'd1);
        chk("rs2_addr_comb", {27'b0, RS2_ADDR}, 32'd31);

        step(32'h00500093, 32'h100, 32'h0, 32'h0, 1, 1, 0, mk(0, 5, 3'b001, 1, 1, 0, 32'h100));
        step(32'hFFF0F113, 32'h104, 32'hA5A5A5A5, 32'h0, 1, 1, 0,
             mk(32'hA5A5A5A5, 32'hFFFFFFFF, 3'b010, 2, 1, 0, 32'h104));
        step(32'h123451B7, 32'h108, 32'h5555, 32'h0, 1, 1, 0, mk(0, 32'h12345000, 3'b000, 3, 1, 0, 32'h108));
        step(32'h0030D213, 32'h10C, 32'h11, 32'h0, 1, 1, 0, mk(32'h11, 32'h23, 3'b101, 4, 1, 0, 32'h10C));
        step(32'h0F00E413, 32'h110, 32'h3C, 32'h0, 1, 1, 0, mk(32'h3C, 32'hF0, 3'b011, 8, 1, 0, 32'h110));
        step(32'h003114B3, 32'h114, 32'h2, 32'hFFFFFFE4, 1, 1, 0, mk(32'h2, 32'h04, 3'b101, 9, 1, 0, 32'h114));
        step(32'h003154B3, 32'h118, 32'h2, 32'hFFFFFFE4, 1, 1, 0, mk(32'h2, 32'h24, 3'b101, 9, 1, 0, 32'h118));
        step(32'h022082B3, 32'h11C, 32'h7, 32'h6, 1, 1, 0, mk(32'h7, 32'h6, 3'b100, 5, 1, 0, 32'h11C));

        for (int i = 0; i < 3; i++) begin
            INSTR_IN = 32'h40000033; IN_VALID = 1; OUT_READY = 0; #1;
            chk("stall_in_ready", {31'b0, IN_READY}, 32'd0);
            step(32'h40000033, 32'h120, 32'h9, 32'h9, 1, 0, 0, none);
            chk("stall_out_valid", {31'b0, OUT_VALID}, 32'd1);
            chk("stall_data2", DATA2, 32'h6);
            chk("stall_alu_select", {29'b0, ALU_SELECT}, 32'd4);
            chk("stall_pc_out", PC_OUT, 32'h11C);
        end
        chk("stall_count_3", {16'b0, STALL_COUNT}, 32'd3);

        step(32'h40000033, 32'h120, 32'h9, 32'h9, 1, 1, 0, mk(0, 0, 3'b000, 0, 0, 1, 32'h120));
        chk("stall_count_hold", {16'b0, STALL_COUNT}, 32'd3);

        step(32'h00500313, 32'h124, 32'h1, 32'h0, 1, 0, 1, none);
        chk("flush_out_valid", {31'b0, OUT_VALID}, 32'd0);
        chk("flush_no_count", {16'b0, STALL_COUNT}, 32'd3);
        step(32'h0, 32'h0, 32'h0, 32'h0, 0, 1, 0, none);
        chk("flush_never_appears", {31'b0, OUT_VALID}, 32'd0);

        step(32'h00100013, 32'h128, 32'h0, 32'h0, 1, 1, 0, mk(0, 1, 3'b001, 0, 0, 0, 32'h128));

        step(32'h00100393, 32'h12C, 32'h0, 32'h0, 1, 1, 0, mk(0, 1, 3'b001, 7, 1, 0, 32'h12C));
        step(32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, none);
        step(32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, none);
        chk("pre_reset_count", {16'b0, STALL_COUNT}, 32'd5);
        chk("pre_reset_valid", {31'b0, OUT_VALID}, 32'd1);
        #1;
        RESET = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, OUT_VALID}, 32'd0);
        chk("async_rst_count", {16'b0, STALL_COUNT}, 32'd0);
        chk("async_rst_data2", DATA2, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        step(32'h00500093, 32'h200, 32'h0, 32'h0, 1, 1, 0, mk(0, 5, 3'b001, 1, 1, 0, 32'h200));
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Producer end of the ALU interface. Decodes an RV32 instruction from IF/ID, reads register operands, and registers the ID/EX bundle: DATA1, DATA2 and a 3-bit ALU select.
- Includes a valid/ready handshake, so a multi-cycle EX operation (MUL) can stall decode.
- Includes a flush input and a saturating stall counter.
- Sits between instruction fetch and the ALU in the 5-stage RV32IM pipeline.

Parameters:
- XLEN, 32, datapath width
- CNT_W, 16, stall counter width

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- INSTR_IN  in  32  instruction word
- PC_IN  in  32  instruction address
- IN_VALID  in  1  INSTR_IN/PC_IN valid
- IN_READY  out  1  stage can accept
- RS1_ADDR  out  5  regfile read address 1, combinational from INSTR_IN[19:15]
- RS2_ADDR  out  5  regfile read address 2, combinational from INSTR_IN[24:20]
- RS1_DATA  in  32  regfile read data 1, combinational
- RS2_DATA  in  32  regfile read data 2, combinational
- FLUSH  in  1  discard held and incoming instruction
- OUT_READY  in  1  EX stage can accept
- OUT_VALID  out  1  registered bundle valid
- DATA1  out  32  ALU operand 1
- DATA2  out  32  ALU operand 2
- ALU_SELECT  out  3  ALU operation
- RD_ADDR  out  5  destination register
- REG_WRITE_EN  out  1  writeback enable
- ILLEGAL  out  1  unsupported instruction
- PC_OUT  out  32  registered PC
- STALL_COUNT  out  CNT_W  cycles with OUT_VALID=1 and OUT_READY=0, saturating

Behaviour:
- Reset: all registered outputs are 0, including OUT_VALID, ALU_SELECT (000) and STALL_COUNT. Reset is asynchronous and may assert mid-stall; the held bundle is dropped.
- IN_READY = !OUT_VALID || OUT_READY (combinational). A transfer occurs when IN_VALID && IN_READY.
- Latency is one cycle: an instruction accepted at edge N appears on the outputs after edge N.
- Output register update, in priority order:
  - FLUSH=1: OUT_VALID<=0 and any same-cycle accept is discarded. FLUSH overrides IN_VALID and OUT_READY. STALL_COUNT does not increment in that cycle.
  - Transfer: load the decoded bundle and set OUT_VALID<=1.
  - OUT_VALID && OUT_READY with no transfer: OUT_VALID<=0 and fields hold their values.
  - Otherwise: hold every output stable. While OUT_VALID=1 and OUT_READY=0, all outputs are frozen.
- ALU_SELECT encoding:
  - 000 FORWARD (result = DATA2)
  - 001 ADD
  - 010 AND
  - 011 OR
  - 100 MUL
  - 101 SHIFT
  - 110 and 111 are never produced.
- Decode, opcode 0010011 (OP-IMM):
  - ADDI (f3=000), ANDI (111), ORI (110): DATA1=RS1_DATA; DATA2=sign-extended I-immediate; select 001, 010 or 011 respectively.
  - SLLI (f3=001, f7=0) and SRLI (f3=101, f7=0): select 101; DATA2[4:0]=shamt, DATA2[5]=1 for right shift, DATA2[31:6]=0.
- Decode, opcode 0110011 (OP):
  - f7=0000000: ADD (f3=000), AND, OR, SLL, SRL as the immediate forms, with DATA2=RS2_DATA. For register shifts DATA2 = {26'b0, f3==101, RS2_DATA[4:0]}.
  - f7=0000001 with f3=000: MUL, select 100, DATA2=RS2_DATA.
- Decode, opcode 0110111 (LUI): select 000, DATA2={imm[31:12],12'b0}, DATA1=0.
- Any other encoding (SUB, SRA, XOR, SLT, loads, branches, other M ops, ...):
  - ILLEGAL=1, REG_WRITE_EN=0, select 000, DATA1=DATA2=0.
  - Still handshaked as a normal bundle.
- REG_WRITE_EN=1 for every legal instruction unless RD_ADDR==0.
- STALL_COUNT increments each cycle OUT_VALID && !OUT_READY && !FLUSH and saturates at all-ones. It is cleared only by RESET.

Decomposition:
- Shared package alu_defs holds:
  - ALU_FORWARD..ALU_SHIFT select constants
  - opcode constants OPC_OP_IMM, OPC_OP, OPC_LUI
  - funct3/funct7 constants
  - a decoded-bundle struct typedef
- One combinational sub-module, rv32_alu_decoder: INSTR_IN, RS1_DATA, RS2_DATA -> DATA1, DATA2, select, rd, write enable, illegal.
- The handshake register and counter stay in alu_decode_stage.

Test Plan:
- addi x1,x0,5 (0x00500093), RS1_DATA=0, OUT_READY=1 -> next cycle OUT_VALID=1, DATA1=0, DATA2=5, ALU_SELECT=001, RD_ADDR=1, REG_WRITE_EN=1.
- andi x2,x1,-1 (0xFFF0F113), RS1_DATA=0xA5A5A5A5 -> DATA2=0xFFFFFFFF, ALU_SELECT=010. lui x3,0x12345 (0x123451B7) -> DATA2=0x12345000, ALU_SELECT=000.
- srli x4,x1,3 (0x0030D213) -> ALU_SELECT=101, DATA2=0x00000023. mul x5,x1,x2 (0x022082B3) -> ALU_SELECT=100, DATA2=RS2_DATA.
- mul held with OUT_READY=0 for 3 cycles while IN_VALID=1 -> IN_READY=0 and outputs frozen for those cycles; STALL_COUNT=3. Next instruction is accepted on the cycle OUT_READY=1.
- FLUSH=1 with OUT_VALID=1 and IN_VALID=1 -> next cycle OUT_VALID=0 and the incoming instruction never appears. Instruction 0x40000033 (SUB) -> ILLEGAL=1, REG_WRITE_EN=0.
- RESET asserted asynchronously mid-stall -> OUT_VALID=0, STALL_COUNT=0 immediately, without waiting for a CLK edge. addi x0,x0,1 -> REG_WRITE_EN=0.
